// File: rtl/grass_strip_renderer.sv
// Animated grass strip layer: bright top row, green body, scrolling blade tufts above.
// Outputs are registered, giving one cycle of latency from x/y/de to color/enable.
package color_pkg;
    typedef logic [11:0] rgb_t;
    localparam rgb_t BLACK        = 12'h000;
    localparam rgb_t GRASS_GREEN  = 12'h0a0;
    localparam rgb_t GRASS_BRIGHT = 12'h3f3;
endpackage

module grass_strip_renderer
    import color_pkg::*;
#(
    parameter int Y_TOP       = 140,
    parameter int HEIGHT      = 10,
    parameter int BLADE_H     = 3,
    parameter int TUFT_PERIOD = 16,
    parameter int TUFT_W      = 2,
    parameter int SCROLL_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       de,
    input  logic       frame_start,
    input  logic       scroll_en,
    input  logic [2:0] speed,
    output rgb_t       color,
    output logic       enable
);
    localparam int LOG2P = $clog2(TUFT_PERIOD);
    localparam int OFF_W = LOG2P + 1;
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [9:0] ROW_TOP   = 10'(Y_TOP);
    localparam logic [9:0] ROW_TUFT  = 10'(Y_TOP + 1);
    localparam logic [9:0] ROW_END   = 10'(Y_TOP + HEIGHT);
    localparam logic [9:0] ROW_BLADE = 10'(Y_TOP - BLADE_H);
    localparam logic [9:0] ROW_SHORT = 10'(Y_TOP - BLADE_H + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [OFF_W-1:0] offset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the pixel on a frame_start edge sees the old offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            offset  <= '0;
        end else if (frame_start && scroll_en) begin
            if (div_cnt == DIV_W'(SCROLL_DIV - 1)) begin
                div_cnt <= '0;
                offset  <= offset + OFF_W'(speed);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Power-of-two modulo on the full sum keeps every bit of x in use.
    logic [10:0] s_full;
    logic        tuft;
    logic        odd;

    assign s_full = {1'b0, x} + 11'(offset);
    assign tuft   = (s_full % 11'(TUFT_PERIOD)) < 11'(TUFT_W);
    assign odd    = (s_full % 11'(2 * TUFT_PERIOD)) >= 11'(TUFT_PERIOD);

    rgb_t color_d;
    logic enable_d;

    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        color_d  = BLACK;
        enable_d = 1'b0;
        if (!de) begin
            color_d  = BLACK;
            enable_d = 1'b0;
        end else if (y == ROW_TOP) begin
            color_d  = GRASS_BRIGHT;
            enable_d = 1'b1;
        end else if (y > ROW_TOP && y < ROW_END) begin
            enable_d = 1'b1;
            color_d  = (tuft && y == ROW_TUFT) ? GRASS_BRIGHT : GRASS_GREEN;
        end else if (y >= ROW_BLADE && y < ROW_TOP) begin
            // Odd tufts are one row shorter, so their top row is one lower.
            if (tuft && y >= (odd ? ROW_SHORT : ROW_BLADE)) begin
                color_d  = GRASS_BRIGHT;
                enable_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color  <= BLACK;
            enable <= 1'b0;
        end else begin
            color  <= color_d;
            enable <= enable_d;
        end
    end
endmodule

// File: tb/tb_grass_strip_renderer.sv
// Self-checking bench for grass_strip_renderer: directed scenarios plus random
// pixels and frame pulses compared against a behavioural model.
module tb_grass_strip_renderer;
    import color_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       de = 1'b0;
    logic       frame_start = 1'b0;
    logic       scroll_en = 1'b0;
    logic [2:0] speed = '0;
    rgb_t       color;
    logic       enable;

    grass_strip_renderer dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de),
        .frame_start(frame_start), .scroll_en(scroll_en), .speed(speed),
        .color(color), .enable(enable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_off = 0;
    int m_div = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pixel rule, defaults: strip at 140..149, blades 137..139, period 16, width 2.
    task automatic model_pixel(input int px, input int py, input bit pde, input int off,
                               output bit en, output rgb_t col);
        int s;
        bit tuft, odd;
        int bh;
        en = 0; col = BLACK;
        s = (px + off) % 32;
        tuft = (s % 16) < 2;
        odd = s >= 16;
        if (!pde) begin
            en = 0; col = BLACK;
        end else if (py == 140) begin
            en = 1; col = GRASS_BRIGHT;
        end else if (py > 140 && py < 150) begin
            en = 1; col = (tuft && py == 141) ? GRASS_BRIGHT : GRASS_GREEN;
        end else if (py >= 137 && py < 140) begin
            bh = odd ? 2 : 3;
            if (tuft && py >= 140 - bh) begin
                en = 1; col = GRASS_BRIGHT;
            end
        end
    endtask

    // Drive one pixel at a falling edge, let it be sampled, check one edge later.
    task automatic pixel(input string tag, input int px, input int py, input bit pde,
                         input bit fs, input bit sen, input int spd);
        bit en_e;
        rgb_t col_e;
        x = 10'(px); y = 10'(py); de = pde;
        frame_start = fs; scroll_en = sen; speed = 3'(spd);
        model_pixel(px, py, pde, m_off, en_e, col_e);
        @(posedge clk);
        if (fs && sen) begin
            if (m_div == 3) begin
                m_div = 0;
                m_off = (m_off + spd) % 32;
            end else begin
                m_div++;
            end
        end
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, ".en"}, 32'(enable), 32'(en_e));
        check({tag, ".col"}, 32'(color), 32'(col_e));
    endtask

    task automatic pulses(input int n, input bit sen, input int spd);
        for (int i = 0; i < n; i++) pixel("pulse", 0, 0, 1'b0, 1'b1, sen, spd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_off = 0; m_div = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // 1. Reset state and static strip with scrolling disabled
        #3;
        check("rst.en", 32'(enable), 32'd0);
        check("rst.col", 32'(color), 32'(BLACK));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulses(10, 1'b0, 3);
        check("static.off", 32'(dut.offset), 32'(m_off));
        check("static.div", 32'(dut.div_cnt), 32'(m_div));

        // 2. Strip rows
        pixel("strip_top", 5, 140, 1, 0, 0, 0);
        pixel("strip_body", 5, 145, 1, 0, 0, 0);
        pixel("strip_tuft", 0, 141, 1, 0, 0, 0);
        pixel("strip_below", 5, 150, 1, 0, 0, 0);
        pixel("strip_de0", 5, 139, 0, 0, 0, 0);
        pixel("strip_last", 7, 149, 1, 0, 0, 0);

        // 3. Blades
        pixel("blade_even", 0, 137, 1, 0, 0, 0);
        pixel("blade_odd_hi", 16, 137, 1, 0, 0, 0);
        pixel("blade_odd", 16, 138, 1, 0, 0, 0);
        pixel("blade_gap", 2, 139, 1, 0, 0, 0);
        pixel("blade_above", 0, 136, 1, 0, 0, 0);

        // 4. Scroll at speed 3
        pulses(4, 1'b1, 3);
        check("scroll4.off", 32'(dut.offset), 32'd3);
        pixel("off3_13", 13, 139, 1, 0, 0, 0);
        pixel("off3_0", 0, 139, 1, 0, 0, 0);
        pulses(4, 1'b1, 3);
        check("scroll8.off", 32'(dut.offset), 32'd6);

        // 6. Asynchronous reset mid-scroll, between clock edges
        pulses(2, 1'b1, 3);
        check("pre_rst.div", 32'(dut.div_cnt), 32'd2);
        pixel("pre_rst", 5, 140, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.en", 32'(enable), 32'd0);
        check("async_rst.col", 32'(color), 32'(BLACK));
        m_off = 0; m_div = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.off", 32'(dut.offset), 32'd0);
        check("post_rst.div", 32'(dut.div_cnt), 32'd0);

        // 5. Frame pulse coincident with a pixel: that pixel uses the old offset
        pulses(3, 1'b1, 3);
        pixel("coinc_old", 13, 139, 1, 1, 1, 3);
        check("coinc.off", 32'(dut.offset), 32'd3);
        pixel("coinc_new", 13, 139, 1, 0, 0, 0);

        // Offset wrap after 44 pulses
        do_reset();
        pulses(44, 1'b1, 3);
        check("wrap.off", 32'(dut.offset), 32'd1);

        // Random pixels with sporadic frame pulses
        for (int i = 0; i < 600; i++) begin
            pixel("rand", int'($urandom_range(0, 639)), int'($urandom_range(132, 155)),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
        end
        check("rand.off", 32'(dut.offset), 32'(m_off));
        check("rand.div", 32'(dut.div_cnt), 32'(m_div));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/grass_strip_renderer.md
# grass_strip_renderer

Parametrised, animated successor to the static grass band renderer. It draws a horizontal grass strip at a configurable row, decorates it with blade tufts above the strip, and scrolls the tuft pattern horizontally at a frame-rate-derived speed. It sits in the VGA pixel pipeline beside the other layer renderers, and its `color`/`enable` pair feeds the layer compositor. Outputs are registered, so the compositor must align the other layers to the latency given under Timing.

## Interface
- `Y_TOP`, default 140: first row of the strip, which is drawn bright; must be ≥ `BLADE_H`.
- `HEIGHT`, default 10: strip height in rows; must be ≥ 2.
- `BLADE_H`, default 3: maximum blade height above `Y_TOP`; must be ≥ 2.
- `TUFT_PERIOD`, default 16: tuft spacing in pixels; power of two, ≥ 4. `LOG2P = $clog2(TUFT_PERIOD)`.
- `TUFT_W`, default 2: blade width in pixels; must be < `TUFT_PERIOD`.
- `SCROLL_DIV`, default 4: frames per scroll step; must be ≥ 1.
- Ports:
  - `clk` in 1: pixel clock.
  - `rst_n` in 1: reset, asynchronous, active-low.
  - `x` in 10: current pixel column, 0..639.
  - `y` in 10: current pixel row, 0..479.
  - `de` in 1: active-video qualifier.
  - `frame_start` in 1: one-cycle pulse per frame, asserted in vertical blanking.
  - `scroll_en` in 1: enables offset advance.
  - `speed` in 3: pixels added to the offset per scroll step; 0 means static.
  - `color` out `rgb_t`: pixel colour, registered.
  - `enable` out 1: this layer owns the pixel, registered.

## Operation
- State:
  - `div_cnt`, width `$clog2(SCROLL_DIV)` (minimum 1).
  - `offset`, width `LOG2P+1`, so it wraps mod 2·`TUFT_PERIOD`.
  - Output registers.
- Scroll update happens only on `frame_start`:
  - If `scroll_en` = 0, nothing changes.
  - Otherwise, if `div_cnt == SCROLL_DIV-1`: `div_cnt` ← 0 and `offset` ← (`offset` + `speed`) mod 2·`TUFT_PERIOD`.
  - Otherwise `div_cnt` increments.
  - `div_cnt` holds its value while `scroll_en` is low.
- Pattern coordinates, computed combinationally from the current `offset`:
  - `s = (x + offset)` using 11-bit sum, then the low `LOG2P+1` bits.
  - `p = s[LOG2P-1:0]`.
  - `odd = s[LOG2P]`.
  - `tuft = (p < TUFT_W)`.
- Pixel classification, evaluated in priority order:
  1. `de` = 0: `enable` 0, `color` BLACK.
  2. `y == Y_TOP`: `enable` 1, GRASS_BRIGHT.
  3. `Y_TOP < y < Y_TOP+HEIGHT`: `enable` 1. GRASS_BRIGHT if `tuft` and `y == Y_TOP+1`, otherwise GRASS_GREEN.
  4. Blade rows, `Y_TOP-BLADE_H ≤ y < Y_TOP`: blade height `bh` = `BLADE_H` when `odd` = 0, `BLADE_H-1` when `odd` = 1. If `tuft` and `y ≥ Y_TOP-bh`, then `enable` 1, GRASS_BRIGHT.
  5. Everything else: `enable` 0, `color` BLACK.
- Colours come from `color_pkg` only: GRASS_BRIGHT, GRASS_GREEN, BLACK.
- Row comparisons are 10-bit unsigned. Parameter constraints guarantee `Y_TOP-BLADE_H` ≥ 0.

## Timing
- Latency: `color`/`enable` reflect the `x`, `y`, `de` sampled on the previous rising edge, so exactly 1 cycle.
- `offset` changes on the edge that samples `frame_start`. A pixel sampled on that same edge uses the old offset, so no mid-pixel change occurs.
- `frame_start` asserted during `de` is legal. Same rule applies: the new offset takes effect from the next sampled pixel.
- Reset values:
  - `color` BLACK.
  - `enable` 0.
  - `offset` 0.
  - `div_cnt` 0.
- Reset is asynchronous: outputs clear on `rst_n` falling without a clock edge, including mid-line or mid-frame.
- First valid output is one cycle after the first edge with `rst_n` high.
- Offset wrap is seamless because the pattern period is 2·`TUFT_PERIOD` and `offset` is taken mod that value.
- No handshake. The block is a pure one-pixel-per-clock stream.

## Test plan
1. **Reset and static strip.** `rst_n`=0 → `color`=BLACK, `enable`=0 immediately. Release reset, then send 10 `frame_start` pulses with `scroll_en`=0 → `offset` stays 0.
2. **Strip rows**, offset 0, `de`=1:
   - (x=5, y=140) → next cycle `enable`=1, GRASS_BRIGHT.
   - (5, 145) → GRASS_GREEN.
   - (0, 141) → GRASS_BRIGHT (tuft).
   - (5, 150) → `enable`=0.
   - (5, 139) with `de`=0 → `enable`=0.
3. **Blades**, offset 0:
   - (0, 137) → `enable`=1 (even tuft, height 3).
   - (16, 137) → `enable`=0 (odd tuft, height 2).
   - (16, 138) → `enable`=1.
   - (2, 139) → `enable`=0.
4. **Scroll**, `scroll_en`=1, `speed`=3:
   - After 4 pulses → `offset`=3.
   - After 8 pulses → 6.
   - After 44 pulses → 33 mod 32 = 1.
   - With `offset`=3: (13, 139) → `enable`=1; (0, 139) → `enable`=0.
5. **Coincident pulse.** `frame_start` on the same edge as pixel (13, 139), with `offset` 0→3 at that edge → that pixel is drawn with offset 0 (`enable`=0). Pixel (13, 139) on the next cycle → `enable`=1.
6. **Reset mid-scroll.** With `offset`=6 and `div_cnt`=2, pulse `rst_n` low between clock edges → `enable`=0 with no clock edge; `offset`=0 and `div_cnt`=0 after release.
